// File: rtl/bt_parser_pkg.sv
// bt_parser_pkg: shared states, ASCII constants and error codes for the button parser.
// Checksum verification is enabled by defining BT_PARSER_CRC_CHECK_EN.
package bt_parser_pkg;
  typedef enum logic [2:0] {IDLE, TYPE, NUM, PRESS, CRC} state_t;
  localparam logic [7:0] START     = 8'h21;
  localparam logic [7:0] TYPE_BTN  = 8'h42;
  localparam logic [7:0] DIGIT_MIN = 8'h31;
  localparam logic [7:0] DIGIT_MAX = 8'h38;
  localparam logic [7:0] REL       = 8'h30;
  localparam logic [7:0] PRS       = 8'h31;
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FMT   = 2'd1;
  localparam logic [1:0] ERR_CRC   = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;
`ifdef BT_PARSER_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= DIGIT_MIN) && (b <= DIGIT_MAX);
  endfunction
endpackage

// File: rtl/bt_idle_timer.sv
// bt_idle_timer: counts clocks since the last byte while a packet is open; strobes on expiry.
module bt_idle_timer #(
  parameter int TIMEOUT_CLKS = 400000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  localparam int W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CLKS - 1);
  logic [W-1:0] cnt_q, cnt_d;
  // a clear in the expiry cycle suppresses the strobe, so an arriving byte wins
  always_comb begin
    expire_o = enable_i && !clear_i && (cnt_q == LAST);
    cnt_d    = (clear_i || expire_o || !enable_i) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
endmodule

// File: rtl/bt_button_parser.sv
// bt_button_parser: frames "!B<n><p><crc>" button packets from the UART byte stream.
// Define BT_PARSER_CRC_CHECK_EN to verify the checksum byte; otherwise it is consumed unchecked.
module bt_button_parser
  import bt_parser_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 400000
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Btn_Valid,
  output logic [3:0] o_Btn_Num,
  output logic       o_Btn_Pressed,
  output logic [7:0] o_Btn_State,
  output logic       o_Err,
  output logic [1:0] o_Err_Code
);
  state_t state_q, state_d;
  logic [7:0] sum_q, sum_d;
  logic [3:0] num_q, num_d;
  logic prs_q, prs_d;
  logic valid_q, valid_d, err_q, err_d, bprs_q, bprs_d;
  logic [1:0] code_q, code_d;
  logic [3:0] bnum_q, bnum_d;
  logic [7:0] bst_q, bst_d;
  logic expire, tmo, fmt_err, crc_done, crc_ok;
  logic [2:0] idx;
  bt_idle_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .clk_i    (i_Clock),
    .rst_ni   (i_Reset_n),
    .clear_i  (i_RX_DV || state_q == IDLE),
    .enable_i (state_q != IDLE),
    .expire_o (expire)
  );
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      num_q   <= '0;
      prs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      num_q   <= num_d;
      prs_q   <= prs_d;
    end
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    num_d    = num_q;
    prs_d    = prs_q;
    fmt_err  = 1'b0;
    crc_done = 1'b0;
    tmo      = 1'b0;
    if (i_RX_DV) begin
      case (state_q)
        IDLE: if (i_RX_Byte == START) begin
          state_d = TYPE;
          sum_d   = START;
        end
        TYPE: if (i_RX_Byte == TYPE_BTN) begin
          state_d = NUM;
          sum_d   = sum_q + i_RX_Byte;
        end else fmt_err = 1'b1;
        NUM: if (is_digit(i_RX_Byte)) begin
          state_d = PRESS;
          sum_d   = sum_q + i_RX_Byte;
          num_d   = i_RX_Byte[3:0];
        end else fmt_err = 1'b1;
        PRESS: if (i_RX_Byte == REL || i_RX_Byte == PRS) begin
          state_d = CRC;
          sum_d   = sum_q + i_RX_Byte;
          prs_d   = i_RX_Byte[0];
        end else fmt_err = 1'b1;
        CRC: begin
          state_d  = IDLE;
          crc_done = 1'b1;
        end
        default: state_d = IDLE;
      endcase
      // a stray '!' mid-packet restarts framing instead of being discarded
      if (fmt_err) begin
        state_d = (i_RX_Byte == START) ? TYPE : IDLE;
        sum_d   = (i_RX_Byte == START) ? START : sum_q;
      end
    end else if (expire) begin
      state_d = IDLE;
      tmo     = 1'b1;
    end
  end
  always_comb begin
    crc_ok  = !CRC_EN || (i_RX_Byte == ~sum_q);
    valid_d = crc_done && crc_ok;
    err_d   = fmt_err || tmo || (crc_done && !crc_ok);
    code_d  = fmt_err ? ERR_FMT : tmo ? ERR_TMO : (crc_done && !crc_ok) ? ERR_CRC : code_q;
    bnum_d  = valid_d ? num_q : bnum_q;
    bprs_d  = valid_d ? prs_q : bprs_q;
    idx     = num_q[2:0] - 3'd1;
    bst_d   = bst_q;
    if (valid_d) bst_d[idx] = prs_q;
  end
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      bnum_q  <= '0;
      bprs_q  <= 1'b0;
      bst_q   <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
      bnum_q  <= bnum_d;
      bprs_q  <= bprs_d;
      bst_q   <= bst_d;
    end
  assign o_Btn_Valid   = valid_q;
  assign o_Err         = err_q;
  assign o_Err_Code    = code_q;
  assign o_Btn_Num     = bnum_q;
  assign o_Btn_Pressed = bprs_q;
  assign o_Btn_State   = bst_q;
endmodule
